link_tx_scheduler: RTL

- Shares one 8b10b encoder between NREQ byte-stream requesters, one frame at a time.
- Frames each granted stream with K-character delimiters and fills the link with K28.5 commas when no frame is in progress.
- Sits directly upstream of the encoder.
- Emits exactly one 9-bit symbol every cycle after reset: bit 8 is the K flag, bits 7:0 are the byte.

---
 rtl/link_tx_pkg.sv | 35 +++
 rtl/link_tx_scheduler_rr_arbiter.sv | 32 +++
 rtl/link_tx_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/link_tx_pkg.sv
// Shared symbol codes, FSM state encoding and CRC-8 helper for the link TX scheduler.
// LINK_TX_CRC8_EN adds the CRC state between the last payload byte and EOF.
package link_tx_pkg;

    localparam logic [8:0] K28_5 = 9'h1BC;
    localparam logic [8:0] K27_7 = 9'h1FB;
    localparam logic [8:0] K29_7 = 9'h1FD;
    localparam logic [8:0] K30_7 = 9'h1FE;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_SOF,
        ST_DATA,
`ifdef LINK_TX_CRC8_EN
        ST_CRC,
`endif
        ST_EOF,
        ST_ABORT,
        ST_DRAIN
    } state_t;

    // MSB-first, non-reflected CRC-8 update by one byte
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr wins; grant is one-hot.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] j;

    // Walk from farthest to nearest so the requester closest to ptr is written last
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        if (en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                j = IW'((int'(ptr) + k) % NREQ);
                if (req[j]) begin
                    grant    = '0;
                    grant[j] = 1'b1;
                    idx      = j;
                end
            end
        end
    end

endmodule

// File: rtl/link_tx_scheduler.sv
// Frames NREQ byte streams onto one 8b10b encoder input, filling with K28.5 between frames.
// Optional macro LINK_TX_CRC8_EN appends a CRC-8 symbol before EOF on normal frames.
module link_tx_scheduler
    import link_tx_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXLEN   = 64,
    parameter int IDLE_GAP = 2,
    parameter int SYNC_LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [8*NREQ-1:0]        req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     enc_push,
    output logic [8:0]               enc_data,
    output logic                     enc_start,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    // state | meaning
    // SYNC  | post-reset comma train, requests ignored
    // IDLE  | comma fill, arbitrate once the gap is met
    // SOF   | emit K27.7 start delimiter
    // DATA  | pass granted bytes, comma on bubbles
    // CRC   | emit payload CRC-8 (LINK_TX_CRC8_EN only)
    // EOF   | emit K29.7 end delimiter
    // ABORT | emit K30.7 after MAXLEN bytes without last
    // DRAIN | pop and discard the rest of the aborted frame

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXLEN + 1);
    localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam int SW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;

    localparam logic [CW-1:0] LEN_TC  = CW'(MAXLEN - 1);
    localparam logic [GW-1:0] GAP_TC  = GW'(IDLE_GAP);
    localparam logic [SW-1:0] SYNC_TC = SW'(SYNC_LEN - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] sync_cnt, sync_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [CW-1:0] byte_cnt, byte_nxt;
    logic [IW-1:0] rr_ptr, ptr_nxt;
    logic [IW-1:0] gid_nxt;
    logic [8:0]    sym_nxt;
    logic          start_nxt;
    logic          busy_nxt;
`ifdef LINK_TX_CRC8_EN
    logic [7:0]    crc, crc_nxt;
`endif

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_en;
    logic            fire;
    logic [7:0]      sel_data;
    logic            sel_last;

    assign arb_en   = (state == ST_IDLE) && (gap_cnt >= GAP_TC);
    assign sel_data = req_data[{grant_id, 3'b000} +: 8];
    assign sel_last = req_last[grant_id];
    assign fire     = |(req_valid & req_ready);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        req_ready = '0;
        if (state == ST_DATA || state == ST_DRAIN) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        sym_nxt   = K28_5;
        start_nxt = 1'b0;
        busy_nxt  = 1'b0;
        sync_nxt  = sync_cnt;
        gap_nxt   = gap_cnt;
        byte_nxt  = byte_cnt;
        ptr_nxt   = rr_ptr;
        gid_nxt   = grant_id;
`ifdef LINK_TX_CRC8_EN
        crc_nxt   = crc;
`endif
        case (state)
            ST_SYNC: begin
                if (sync_cnt == SYNC_TC) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = GAP_TC;
                end else begin
                    sync_nxt = sync_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (gap_cnt != GAP_TC) begin
                    gap_nxt = gap_cnt + 1'b1;
                end
                if (|arb_grant) begin
                    gid_nxt   = arb_idx;
                    ptr_nxt   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_nxt = ST_SOF;
                end
            end
            ST_SOF: begin
                sym_nxt   = K27_7;
                start_nxt = 1'b1;
                busy_nxt  = 1'b1;
                byte_nxt  = '0;
`ifdef LINK_TX_CRC8_EN
                crc_nxt   = '0;
`endif
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                busy_nxt = 1'b1;
                if (fire) begin
                    sym_nxt  = {1'b0, sel_data};
                    byte_nxt = byte_cnt + 1'b1;
`ifdef LINK_TX_CRC8_EN
                    crc_nxt  = crc8_next(crc, sel_data);
                    if (sel_last) begin
                        state_nxt = ST_CRC;
                    end else if (byte_cnt == LEN_TC) begin
                        state_nxt = ST_ABORT;
                    end
`else
                    if (sel_last) begin
                        state_nxt = ST_EOF;
                    end else if (byte_cnt == LEN_TC) begin
                        state_nxt = ST_ABORT;
                    end
`endif
                end
            end
`ifdef LINK_TX_CRC8_EN
            ST_CRC: begin
                sym_nxt   = {1'b0, crc};
                busy_nxt  = 1'b1;
                state_nxt = ST_EOF;
            end
`endif
            ST_EOF: begin
                sym_nxt   = K29_7;
                busy_nxt  = 1'b1;
                gap_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                sym_nxt   = K30_7;
                busy_nxt  = 1'b1;
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy_nxt = 1'b1;
                if (fire && sel_last) begin
                    gap_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SYNC;
            sync_cnt  <= '0;
            gap_cnt   <= '0;
            byte_cnt  <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            enc_push  <= 1'b0;
            enc_data  <= K28_5;
            enc_start <= 1'b0;
            busy      <= 1'b0;
`ifdef LINK_TX_CRC8_EN
            crc       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            sync_cnt  <= sync_nxt;
            gap_cnt   <= gap_nxt;
            byte_cnt  <= byte_nxt;
            rr_ptr    <= ptr_nxt;
            grant_id  <= gid_nxt;
            enc_push  <= 1'b1;
            enc_data  <= sym_nxt;
            enc_start <= start_nxt;
            busy      <= busy_nxt;
`ifdef LINK_TX_CRC8_EN
            crc       <= crc_nxt;
`endif
        end
    end

endmodule
